// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the 3-wide common data bus arbiter.
package cdb_arbiter_pkg;

    localparam int NUM_FU = 6;
    localparam int PR     = 6;
    localparam int XLEN   = 32;
    localparam int CDB_W  = 3;
    localparam int PTR_W  = $clog2(NUM_FU);

    localparam logic [PR-1:0] ZERO_PR = {PR{1'b0}};

    typedef struct packed {
        logic [PR-1:0] t2;
        logic [PR-1:0] t1;
        logic [PR-1:0] t0;
    } CDB_T_PACKET;

    // Reduce a sum of two FU indices (each < NUM_FU) back into 0..NUM_FU-1.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] a);
        logic [PTR_W:0] lim;
        lim = (PTR_W+1)'(NUM_FU);
        return (a >= lim) ? PTR_W'(a - lim) : a[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_checker.sv
// Protocol checks for the CDB arbiter: no two live FUs target the same register.
module cdb_arbiter_checker
    import cdb_arbiter_pkg::*;
(
    input logic                       clock,
    input logic                       reset,
    input logic [NUM_FU-1:0]          fu_valid,
    input logic [NUM_FU-1:0][PR-1:0]  fu_tag
);

    logic dup_s;

    // Pairwise compare of live destination tags.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = i + 1; j < NUM_FU; j++) begin
                dup_s = dup_s | (fu_valid[i] && fu_valid[j] && (fu_tag[i] != ZERO_PR)
                                 && (fu_tag[i] == fu_tag[j]));
            end
        end
    end

    a_no_dup_live_tag: assert property (@(posedge clock) disable iff (reset) !dup_s);

endmodule

// File: rtl/cdb_arbiter_rr_pick3.sv
// Combinational round-robin picker: up to three live requests, scanning from rr_ptr.
module cdb_arbiter_rr_pick3
    import cdb_arbiter_pkg::*;
(
    input  logic [NUM_FU-1:0]             live_mask,
    input  logic [PTR_W-1:0]              rr_ptr,
    output logic [NUM_FU-1:0]             grant_mask,
    output logic [CDB_W-1:0][NUM_FU-1:0]  slot_sel,
    output logic [CDB_W-1:0]              slot_valid,
    output logic [PTR_W-1:0]              next_ptr
);

    logic [NUM_FU-1:0]            rot_s;
    logic [CDB_W-1:0][PTR_W-1:0]  pos_s;
    logic [CDB_W-1:0][PTR_W-1:0]  orig_s;
    logic [1:0]                   found_s;
    logic [PTR_W-1:0]             last_s;

    // Rotate so rr_ptr lands at bit 0, encode three deep, then rotate back.
    always_comb begin
        rot_s      = '0;
        pos_s      = '0;
        orig_s     = '0;
        slot_valid = '0;
        slot_sel   = '0;
        found_s    = 2'd0;
        for (int j = 0; j < NUM_FU; j++) begin
            rot_s[j] = live_mask[wrap_idx({1'b0, PTR_W'(j)} + {1'b0, rr_ptr})];
        end
        for (int j = 0; j < NUM_FU; j++) begin
            if (rot_s[j] && (found_s != 2'd3)) begin
                pos_s[found_s]      = PTR_W'(j);
                slot_valid[found_s] = 1'b1;
                found_s             = found_s + 2'd1;
            end else begin
                found_s = found_s;
            end
        end
        for (int k = 0; k < CDB_W; k++) begin
            orig_s[k] = wrap_idx({1'b0, pos_s[k]} + {1'b0, rr_ptr});
            slot_sel[k][orig_s[k]] = slot_valid[k];
        end
        grant_mask = slot_sel[0] | slot_sel[1] | slot_sel[2];
        last_s = slot_valid[2] ? orig_s[2] : (slot_valid[1] ? orig_s[1] : orig_s[0]);
        next_ptr = slot_valid[0] ? wrap_idx({1'b0, last_s} + {1'b0, PTR_W'(1)}) : rr_ptr;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: grants up to three live FU results per cycle onto a registered CDB.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU-1:0][PR-1:0]   fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0] fu_data,
    output logic [NUM_FU-1:0]           fu_ready,
    output CDB_T_PACKET                 cdb_packet,
    output logic [CDB_W-1:0][XLEN-1:0]  cdb_data,
    output logic [1:0]                  cdb_count
);

    logic [PTR_W-1:0]             rr_ptr_r;
    logic [PTR_W-1:0]             next_ptr_s;
    logic [NUM_FU-1:0]            live_s;
    logic [NUM_FU-1:0]            null_s;
    logic [NUM_FU-1:0]            grant_s;
    logic [CDB_W-1:0][NUM_FU-1:0] sel_s;
    logic [CDB_W-1:0]             slot_vld_s;
    logic [CDB_W-1:0][PR-1:0]     slot_tag_s;
    logic [CDB_W-1:0][XLEN-1:0]   slot_data_s;
    logic [1:0]                   slot_cnt_s;

    // Split requests into live (needs a slot) and null (no destination register).
    always_comb begin
        live_s = '0;
        null_s = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            live_s[i] = fu_valid[i] && (fu_tag[i] != ZERO_PR);
            null_s[i] = fu_valid[i] && (fu_tag[i] == ZERO_PR);
        end
    end

    cdb_arbiter_rr_pick3 u_pick (
        .live_mask  (live_s),
        .rr_ptr     (rr_ptr_r),
        .grant_mask (grant_s),
        .slot_sel   (sel_s),
        .slot_valid (slot_vld_s),
        .next_ptr   (next_ptr_s)
    );

    // Null requests are always accepted; nothing is accepted under reset or squash.
    always_comb begin
        if (reset || squash) begin
            fu_ready = '0;
        end else begin
            fu_ready = grant_s | null_s;
        end
    end

    // One-hot slot muxes for tags and data; empty slots fall out as zero.
    always_comb begin
        slot_tag_s  = '0;
        slot_data_s = '0;
        for (int k = 0; k < CDB_W; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                slot_tag_s[k]  = slot_tag_s[k]  | (sel_s[k][i] ? fu_tag[i]  : ZERO_PR);
                slot_data_s[k] = slot_data_s[k] | (sel_s[k][i] ? fu_data[i] : {XLEN{1'b0}});
            end
        end
        slot_cnt_s = {1'b0, slot_vld_s[0]} + {1'b0, slot_vld_s[1]} + {1'b0, slot_vld_s[2]};
    end

    // CDB output register and round-robin pointer; squash empties the bus and freezes the pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= '0;
            cdb_packet <= '{t2: ZERO_PR, t1: ZERO_PR, t0: ZERO_PR};
            cdb_data   <= '0;
            cdb_count  <= 2'd0;
        end else if (squash) begin
            rr_ptr_r   <= rr_ptr_r;
            cdb_packet <= '{t2: ZERO_PR, t1: ZERO_PR, t0: ZERO_PR};
            cdb_data   <= '0;
            cdb_count  <= 2'd0;
        end else begin
            rr_ptr_r   <= next_ptr_s;
            cdb_packet <= '{t2: slot_tag_s[2], t1: slot_tag_s[1], t0: slot_tag_s[0]};
            cdb_data   <= slot_data_s;
            cdb_count  <= slot_cnt_s;
        end
    end

    cdb_arbiter_checker u_chk (
        .clock    (clock),
        .reset    (reset),
        .fu_valid (fu_valid),
        .fu_tag   (fu_tag)
    );

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates writeback of up to NUM_FU completing functional units onto the 3-wide CDB.
- The registered CDB packet drives the physical register file write port (t0/t1/t2 tags plus 3 data words), plus wakeup and ROB completion.
- Grants up to 3 requests per cycle with rotating (round-robin) priority so no FU starves.
- Ungranted FUs hold their result through a valid/ready handshake.

Parameters:
- NUM_FU, 6, number of requesting functional units.
- PR, 6, physical register index width (2**PR physical registers).
- XLEN, 32, data width.
- CDB_W, 3, broadcast slots per cycle; fixed at 3 to match the regfile write port.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  pipeline flush; drops the current cycle's grants and clears the CDB register.
- fu_valid  in  NUM_FU  FU i holds a completed result.
- fu_tag  in  NUM_FU x PR  destination physical register; ZERO_PR means no destination.
- fu_data  in  NUM_FU x XLEN  result value.
- fu_ready  out  NUM_FU  combinational grant; the result is accepted this cycle when valid and ready are both high.
- cdb_packet  out  CDB_T_PACKET  registered tags t0, t1, t2; an unused slot carries ZERO_PR.
- cdb_data  out  3 x XLEN  registered data aligned with t0..t2.
- cdb_count  out  2  number of live slots in cdb_packet (0..3).

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - rr_ptr=0.
  - cdb_packet t0/t1/t2=ZERO_PR, cdb_data=0, cdb_count=0.
  - fu_ready is combinational: 0 during reset.
- Eligibility:
  - FU i is live when fu_valid[i]=1 and fu_tag[i]!=ZERO_PR.
  - FU i is null when fu_valid[i]=1 and fu_tag[i]==ZERO_PR, e.g. stores and branches.
- Null requests:
  - fu_ready[i]=1 whenever squash=0.
  - Consume no slot and are never broadcast.
- Live request selection:
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first min(3, #live) live FUs are granted, fu_ready=1.
  - All other live FUs get fu_ready=0 and must hold valid/tag/data stable.
- Slot order: first-found → t0, second → t1, third → t2. Unused slots → ZERO_PR, data 0.
- Latency: grant in cycle N; cdb_packet/cdb_data/cdb_count valid in cycle N+1 for exactly one cycle. The regfile writes at the end of N+1.
- rr_ptr update:
  - If ≥1 live grant: rr_ptr ← (index of last granted live FU + 1) mod NUM_FU.
  - Otherwise rr_ptr is unchanged.
  - Null grants do not move rr_ptr.
- Squash=1 in cycle N:
  - All fu_ready=0.
  - CDB register ← empty (ZERO_PR, 0, count 0) in N+1.
  - rr_ptr unchanged.
  - A packet already registered in cycle N is still presented in N; squash only affects N+1.
- Fewer than 3 live requests: all granted same cycle, no wait.
- 0 live requests: CDB register empty next cycle.
- Duplicate live tags from two FUs are illegal. An assertion flags them; no arbitration special case.
- Wrap-around: the scan crosses index NUM_FU-1 → 0 seamlessly.
- Starvation bound: a continuously live FU is granted within ceil(NUM_FU/3) cycles.
- No combinational path from fu_valid/fu_tag to cdb_* outputs.

Decomposition:
- Shared package holds:
  - CDB_T_PACKET typedef (t0, t1, t2 of PR bits).
  - ZERO_PR constant.
  - CDB_W constant.
- Top block holds: rr_ptr register, output register, squash gating, null-request handling, assertion.
- One sub-module, rr_pick3:
  - Purely combinational.
  - Inputs: live mask, rr_ptr.
  - Outputs: grant mask, three one-hot slot selects with valid bits, next rr_ptr.
  - Implemented by rotating the mask by rr_ptr, running a 3-deep priority encode, and rotating back.

Test Plan:
- Reset then idle → cdb_packet all ZERO_PR, cdb_count=0, fu_ready all 0 during reset and 0 for idle FUs after.
- rr_ptr=0; FU0,1,2,4 live (tags 5,9,12,20; data 0xA,0xB,0xC,0xD) → ready=0b000111. Next cycle t0=5,t1=9,t2=12, data A,B,C, count=3, rr_ptr=3. Following grant → FU4 in t0 (tag 20, 0xD), rr_ptr=5.
- rr_ptr=4; FU5 and FU1 live, FU3 null → ready=0b101010. Next cycle t0=FU5 tag, t1=FU1 tag, t2=ZERO_PR, count=2, rr_ptr=2; FU3 not broadcast.
- All 6 FUs held live continuously → each granted exactly once in 2 consecutive cycles; grants alternate 0-2 then 3-5.
- Squash asserted in a cycle with 3 live requests → ready all 0, next cycle count=0 and tags ZERO_PR, rr_ptr unchanged. The same requests are granted the cycle after squash deasserts.
- Reset asserted asynchronously mid-cycle while count=3 → outputs clear immediately without waiting for a clock edge, rr_ptr=0. After release, arbitration restarts at FU0.
